// File: rtl/mdr_pkg.sv
// Shared constants for the memory data register / load formatter.
// Load-type codes, FSM state encoding and lane-extraction constants.
package mdr_pkg;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Reserved codes 101-111 decode as LW, so they share its rule.
    function automatic logic misaligned(input logic [2:0] lt,
                                        input logic [1:0] off);
        logic bad;
        case (lt)
            LT_LB, LT_LBU: bad = 1'b0;
            LT_LH, LT_LHU: bad = off[0];
            default:       bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select and sign/zero extension of a little-endian read word.
// Purely combinational; driven from the latched offset and load type.
module load_extract
    import mdr_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [2:0]        ltype,
    output logic [WORD_W-1:0] data
);

    logic [HALF_W-1:0] lane_h;
    logic [BYTE_W-1:0] lane_b;

    always_comb begin
        lane_h = off[1] ? word[31:16] : word[15:0];
        lane_b = word[{off, 3'b000} +: BYTE_W];
        case (ltype)
            LT_LH:   data = {{(WORD_W-HALF_W){lane_h[HALF_W-1]}}, lane_h};
            LT_LHU:  data = {{(WORD_W-HALF_W){1'b0}}, lane_h};
            LT_LB:   data = {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
            LT_LBU:  data = {{(WORD_W-BYTE_W){1'b0}}, lane_b};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mdr_load_unit.sv
// Memory data register: one read per load, ack timeout, formatted result.
// Define MDR_ALIGN_CHK_EN to reject misaligned LW/LH/LHU without a bus read.
module mdr_load_unit
    import mdr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LoadStart,
    input  logic [2:0]        LoadType,
    input  logic [DATA_W-1:0] AddrIn,
    output logic              MemReq,
    output logic [DATA_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic [DATA_W-1:0] MDRtoMux2,
    output logic              MDRValid,
    output logic              Busy,
    output logic              LoadErr
);

    // The cycle that would push the counter to all-ones is the timeout.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        lt_q, lt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              bad_align;
    logic [DATA_W-1:0] ext_data;

    load_extract u_extract (
        .word  (MemRData),
        .off   (off_q),
        .ltype (lt_q),
        .data  (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mdr_d     = mdr_q;
        off_d     = off_q;
        lt_d      = lt_q;
        tmo_d     = tmo_q;
        valid_d   = valid_q;
        err_d     = err_q;
        bad_align = 1'b0;
`ifdef MDR_ALIGN_CHK_EN
        bad_align = misaligned(LoadType, AddrIn[1:0]);
`else
        bad_align = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (LoadStart) begin
                    addr_d  = {AddrIn[DATA_W-1:2], 2'b00};
                    off_d   = AddrIn[1:0];
                    lt_d    = LoadType;
                    tmo_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    if (bad_align) begin
                        mdr_d   = '0;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (MemAck) begin
                    mdr_d   = ext_data;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '1;
                    mdr_d   = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            mdr_q   <= '0;
            off_q   <= '0;
            lt_q    <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mdr_q   <= mdr_d;
            off_q   <= off_d;
            lt_q    <= lt_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign MemReq    = (state_q == ST_REQ);
    assign Busy      = (state_q != ST_IDLE);
    assign MemAddr   = addr_q;
    assign MDRtoMux2 = mdr_q;
    assign MDRValid  = valid_q;
    assign LoadErr   = err_q;

endmodule

// File: tb/tb_mdr_load_unit.sv
// Scoreboard bench for mdr_load_unit with a 4-bit ack timeout.
// Expected load results are queued at issue and popped at MDRValid.
module tb_mdr_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        LoadStart = 1'b0;
    logic [2:0]  LoadType = 3'b000;
    logic [31:0] AddrIn = '0;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;
    logic [31:0] MDRtoMux2;
    logic        MDRValid;
    logic        Busy;
    logic        LoadErr;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  lt;
        logic [31:0] word;
        int          dly;
        bit          extra;
        logic [31:0] exp;
    } vec_t;

    mdr_load_unit #(.DATA_W(32), .TMO_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .LoadStart (LoadStart),
        .LoadType  (LoadType),
        .AddrIn    (AddrIn),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemAck    (MemAck),
        .MemRData  (MemRData),
        .MDRtoMux2 (MDRtoMux2),
        .MDRValid  (MDRValid),
        .Busy      (Busy),
        .LoadErr   (LoadErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] w,
                                            input logic [1:0] off,
                                            input logic [2:0] lt);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (32'(off) * 8));
        h = off[1] ? w[31:16] : w[15:0];
        case (lt)
            3'd1:    return 32'($signed(h));
            3'd2:    return {16'h0, h};
            3'd3:    return 32'($signed(b));
            3'd4:    return {24'h0, b};
            default: return w;
        endcase
    endfunction

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
        chk({tag, "_valid"}, {31'b0, MDRValid}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, MDRtoMux2, e.data);
            chk({tag, "_err"}, {31'b0, LoadErr}, {31'b0, e.err});
        end
    endtask

    task automatic do_load(input vec_t v);
        int req_n;
        req_n = 0;
        sb.push_back('{v.exp, 1'b0});
        AddrIn    = v.addr;
        LoadType  = v.lt;
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        chk("memaddr", MemAddr, {v.addr[31:2], 2'b00});
        chk("valid_clr", {31'b0, MDRValid}, 32'd0);
        for (int i = 0; i < v.dly; i++) begin
            if (MemReq) req_n++;
            if (v.extra) begin
                LoadStart = 1'b1;
                AddrIn    = v.addr ^ 32'h0000_0440;
                LoadType  = 3'd3;
            end
            tick();
            LoadStart = 1'b0;
            chk("wait_valid", {31'b0, MDRValid}, 32'd0);
            chk("addr_hold", MemAddr, {v.addr[31:2], 2'b00});
        end
        if (MemReq) req_n++;
        MemAck   = 1'b1;
        MemRData = v.word;
        tick();
        MemAck   = 1'b0;
        MemRData = $urandom;
        chk("req_cycles", 32'(req_n), 32'(v.dly + 1));
        chk("req_drop", {31'b0, MemReq}, 32'd0);
        pop_cmp("load");
        if (v.extra) begin
            tick();
            chk("no_queue", {31'b0, Busy}, 32'd0);
            chk("hold", MDRtoMux2, v.exp);
        end
    endtask

    vec_t tbl[9] = '{
        '{32'h100, 3'd0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF},
        '{32'h103, 3'd3, 32'h80FF7F01, 0, 1'b0, 32'hFFFFFF80},
        '{32'h103, 3'd4, 32'h80FF7F01, 1, 1'b0, 32'h00000080},
        '{32'h102, 3'd1, 32'h80FF7F01, 0, 1'b0, 32'hFFFF80FF},
        '{32'h100, 3'd2, 32'h80FF7F01, 2, 1'b0, 32'h00007F01},
        '{32'h101, 3'd3, 32'h80FF7F01, 0, 1'b0, 32'h0000007F},
        '{32'h102, 3'd4, 32'h80FF7F01, 0, 1'b0, 32'h000000FF},
        '{32'h200, 3'd7, 32'h12345678, 0, 1'b0, 32'h12345678},
        '{32'h300, 3'd0, 32'hCAFEF00D, 5, 1'b1, 32'hCAFEF00D}
    };

    initial begin
        vec_t v;
        int   req_n;
        logic [1:0] off;

        #12;
        chk("rst_req", {31'b0, MemReq}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_valid", {31'b0, MDRValid}, 32'd0);
        chk("rst_err", {31'b0, LoadErr}, 32'd0);
        chk("rst_data", MDRtoMux2, 32'd0);
        chk("rst_addr", MemAddr, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", {31'b0, Busy}, 32'd0);

        foreach (tbl[i]) do_load(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            v.lt = 3'($urandom_range(0, 4));
            off  = 2'($urandom_range(0, 3));
            if (v.lt == 3'd0) off = 2'b00;
            if (v.lt == 3'd1 || v.lt == 3'd2) off[0] = 1'b0;
            v.addr  = {$urandom, 2'b00} | {30'b0, off};
            v.word  = $urandom;
            v.dly   = $urandom_range(0, 3);
            v.extra = 1'b0;
            v.exp   = ref_ext(v.word, off, v.lt);
            do_load(v);
        end

        // Ack never arrives: 15 request cycles then an error result.
        sb.push_back('{32'h0, 1'b1});
        AddrIn = 32'h400; LoadType = 3'd0; LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        req_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (MDRValid) break;
            if (MemReq) req_n++;
            tick();
        end
        chk("tmo_cycles", 32'(req_n), 32'd15);
        chk("tmo_req", {31'b0, MemReq}, 32'd0);
        pop_cmp("tmo");

        AddrIn = 32'h500; LoadType = 3'd0; LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        chk("err_clr", {31'b0, LoadErr}, 32'd0);
        chk("valid_clr2", {31'b0, MDRValid}, 32'd0);
        sb.push_back('{32'hA5A5_0001, 1'b0});
        MemAck = 1'b1; MemRData = 32'hA5A5_0001;
        tick();
        MemAck = 1'b0;
        pop_cmp("after_tmo");

        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk("idle_ack_busy", {31'b0, Busy}, 32'd0);
        chk("idle_ack_data", MDRtoMux2, 32'hA5A5_0001);

`ifdef MDR_ALIGN_CHK_EN
        sb.push_back('{32'h0, 1'b1});
        AddrIn = 32'h101; LoadType = 3'd0; LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        chk("mis_req", {31'b0, MemReq}, 32'd0);
        chk("mis_busy", {31'b0, Busy}, 32'd0);
        pop_cmp("mis");
        tick();
        chk("mis_req2", {31'b0, MemReq}, 32'd0);
`else
        v = '{32'h101, 3'd0, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D};
        do_load(v);
`endif

        // Reset in the middle of a request drops MemReq at once.
        AddrIn = 32'h600; LoadType = 3'd0; LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        chk("pre_rst_req", {31'b0, MemReq}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'b0, MemReq}, 32'd0);
        chk("async_busy", {31'b0, Busy}, 32'd0);
        chk("async_valid", {31'b0, MDRValid}, 32'd0);
        chk("async_data", MDRtoMux2, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("after_rst_busy", {31'b0, Busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
